// File: rtl/rename_reg_file.sv
// Architectural register file with rename tracking: each register carries a busy bit and the
// RoB tag of its latest in-flight writer; read ports bypass commit and RoB results combinationally.
module rename_reg_file #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ROB_W  = 4,
    parameter int NRD    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic [ROB_W-1:0]        issue_tag,
    input  logic [REG_AW-1:0]       issue_rd,
    input  logic [ROB_W-1:0]        commit_tag,
    input  logic [REG_AW-1:0]       commit_rd,
    input  logic [XLEN-1:0]         commit_value,
    input  logic [NRD*REG_AW-1:0]   rs_addr,
    output logic [NRD*ROB_W-1:0]    rob_q_tag,
    input  logic [NRD-1:0]          rob_q_ready,
    input  logic [NRD*XLEN-1:0]     rob_q_value,
    output logic [NRD*XLEN-1:0]     rs_value,
    output logic [NRD-1:0]          rs_dep,
    output logic [NRD*ROB_W-1:0]    rs_tag
);

    localparam int NREG = 1 << REG_AW;

    logic [XLEN-1:0]  value_r [NREG];
    logic [NREG-1:0]  busy_r;
    logic [ROB_W-1:0] tag_r   [NREG];

    logic commit_en_s;
    logic commit_clr_s;
    logic issue_en_s;

    // Qualify issue/commit requests; x0 is never a destination.
    always_comb begin
        commit_en_s  = rdy && (commit_tag != {ROB_W{1'b0}}) && (commit_rd != {REG_AW{1'b0}});
        commit_clr_s = commit_en_s && busy_r[commit_rd] && (tag_r[commit_rd] == commit_tag);
        issue_en_s   = rdy && !flush && (issue_tag != {ROB_W{1'b0}}) && (issue_rd != {REG_AW{1'b0}});
    end

    // Register state update; a later issue assignment overrides a same-register commit clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
            for (int i = 0; i < NREG; i++) begin
                value_r[i] <= {XLEN{1'b0}};
                tag_r[i]   <= {ROB_W{1'b0}};
            end
        end else if (rdy) begin
            if (commit_en_s) begin
                value_r[commit_rd] <= commit_value;
            end
            if (flush) begin
                busy_r <= {NREG{1'b0}};
                for (int i = 0; i < NREG; i++) begin
                    tag_r[i] <= {ROB_W{1'b0}};
                end
            end else begin
                if (commit_clr_s) begin
                    busy_r[commit_rd] <= 1'b0;
                    tag_r[commit_rd]  <= {ROB_W{1'b0}};
                end
                if (issue_en_s) begin
                    busy_r[issue_rd] <= 1'b1;
                    tag_r[issue_rd]  <= issue_tag;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [REG_AW-1:0] addr_s;
        logic              busy_s;
        logic [ROB_W-1:0]  tag_s;

        assign addr_s = rs_addr[k*REG_AW +: REG_AW];
        assign busy_s = busy_r[addr_s];
        assign tag_s  = tag_r[addr_s];

        // Operand resolution against pre-edge state: x0, settled value, commit bypass, RoB result, pending.
        always_comb begin
            rs_value[k*XLEN +: XLEN]   = {XLEN{1'b0}};
            rs_dep[k]                  = 1'b0;
            rs_tag[k*ROB_W +: ROB_W]   = {ROB_W{1'b0}};
            rob_q_tag[k*ROB_W +: ROB_W] = busy_s ? tag_s : {ROB_W{1'b0}};
            if (addr_s == {REG_AW{1'b0}}) begin
                rs_value[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (!busy_s) begin
                rs_value[k*XLEN +: XLEN] = value_r[addr_s];
            end else if ((commit_tag == tag_s) && (tag_s != {ROB_W{1'b0}})) begin
                rs_value[k*XLEN +: XLEN] = commit_value;
            end else if (rob_q_ready[k]) begin
                rs_value[k*XLEN +: XLEN] = rob_q_value[k*XLEN +: XLEN];
            end else begin
                rs_dep[k]                = 1'b1;
                rs_tag[k*ROB_W +: ROB_W] = tag_s;
            end
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed self-checking bench for rename_reg_file: each port is observed as {dep, tag, rob_q_tag, value}.
module tb_rename_reg_file;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic [3:0]  issue_tag, commit_tag;
    logic [4:0]  issue_rd, commit_rd;
    logic [31:0] commit_value;
    logic [9:0]  rs_addr;
    logic [7:0]  rob_q_tag;
    logic [1:0]  rob_q_ready;
    logic [63:0] rob_q_value;
    logic [63:0] rs_value;
    logic [1:0]  rs_dep;
    logic [7:0]  rs_tag;

    int vectors = 0;
    int miscompares = 0;

    logic [40:0] p0, p1;
    assign p0 = {rs_dep[0], rs_tag[3:0], rob_q_tag[3:0], rs_value[31:0]};
    assign p1 = {rs_dep[1], rs_tag[7:4], rob_q_tag[7:4], rs_value[63:32]};

    rename_reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_tag(issue_tag), .issue_rd(issue_rd),
        .commit_tag(commit_tag), .commit_rd(commit_rd), .commit_value(commit_value),
        .rs_addr(rs_addr), .rob_q_tag(rob_q_tag), .rob_q_ready(rob_q_ready),
        .rob_q_value(rob_q_value), .rs_value(rs_value), .rs_dep(rs_dep), .rs_tag(rs_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0;
        issue_tag = 4'd0; issue_rd = 5'd0;
        commit_tag = 4'd0; commit_rd = 5'd0; commit_value = 32'd0;
        rob_q_ready = 2'b00; rob_q_value = 64'd0;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; rs_addr = 10'd0;
        tick(); tick();
        rst = 1'b0;
        issue_tag = 4'd3; issue_rd = 5'd5;
        commit_tag = 4'd9; commit_rd = 5'd4; commit_value = 32'h44;
        tick(); idle();
        rs_addr = {5'd4, 5'd5};
        #1;
        vectors++;
        if (p0 !== {1'b1, 4'd3, 4'd3, 32'd0}) begin
            miscompares++; $display("FAIL pre_reset_busy got %h want %h", p0, {1'b1, 4'd3, 4'd3, 32'd0});
        end
        vectors++;
        if (p1 !== {1'b0, 4'd0, 4'd0, 32'h44}) begin
            miscompares++; $display("FAIL pre_reset_value got %h want %h", p1, {1'b0, 4'd0, 4'd0, 32'h44});
        end
        rst = 1'b1; rdy = 1'b0;
        tick();
        rst = 1'b0; rdy = 1'b1;
        #1;
        vectors++;
        if ({p0, p1} !== 82'd0) begin
            miscompares++; $display("FAIL reset_outputs got %h want 0", {p0, p1});
        end
    endtask

    task automatic test_issue();
        idle();
        issue_tag = 4'd3; issue_rd = 5'd5; rs_addr = {5'd0, 5'd5};
        #1;
        vectors++;
        if (p0 !== 41'd0) begin
            miscompares++; $display("FAIL issue_same_cycle got %h want 0", p0);
        end
        tick(); idle();
        #1;
        vectors++;
        if (p0 !== {1'b1, 4'd3, 4'd3, 32'd0}) begin
            miscompares++; $display("FAIL issue_dep got %h want %h", p0, {1'b1, 4'd3, 4'd3, 32'd0});
        end
        rob_q_ready = 2'b01; rob_q_value = {32'd0, 32'h1234};
        #1;
        vectors++;
        if (p0 !== {1'b0, 4'd0, 4'd3, 32'h1234}) begin
            miscompares++; $display("FAIL rob_bypass got %h want %h", p0, {1'b0, 4'd0, 4'd3, 32'h1234});
        end
    endtask

    task automatic test_commit();
        idle();
        commit_tag = 4'd3; commit_rd = 5'd5; commit_value = 32'hDEAD;
        #1;
        vectors++;
        if (p0 !== {1'b0, 4'd0, 4'd3, 32'hDEAD}) begin
            miscompares++; $display("FAIL commit_bypass got %h want %h", p0, {1'b0, 4'd0, 4'd3, 32'hDEAD});
        end
        tick(); idle();
        #1;
        vectors++;
        if (p0 !== {1'b0, 4'd0, 4'd0, 32'hDEAD}) begin
            miscompares++; $display("FAIL commit_clear got %h want %h", p0, {1'b0, 4'd0, 4'd0, 32'hDEAD});
        end
    endtask

    task automatic test_rename_chain();
        idle();
        issue_tag = 4'd3; issue_rd = 5'd5;
        tick();
        issue_tag = 4'd7;
        tick(); idle();
        commit_tag = 4'd3; commit_rd = 5'd5; commit_value = 32'hBEEF;
        #1;
        vectors++;
        if (p0 !== {1'b1, 4'd7, 4'd7, 32'd0}) begin
            miscompares++; $display("FAIL stale_commit_read got %h want %h", p0, {1'b1, 4'd7, 4'd7, 32'd0});
        end
        tick(); idle();
        #1;
        vectors++;
        if (p0 !== {1'b1, 4'd7, 4'd7, 32'd0}) begin
            miscompares++; $display("FAIL newer_rename_kept got %h want %h", p0, {1'b1, 4'd7, 4'd7, 32'd0});
        end
        flush = 1'b1;
        tick(); idle();
        #1;
        vectors++;
        if (p0 !== {1'b0, 4'd0, 4'd0, 32'hBEEF}) begin
            miscompares++; $display("FAIL stale_commit_value got %h want %h", p0, {1'b0, 4'd0, 4'd0, 32'hBEEF});
        end
    endtask

    task automatic test_same_cycle();
        idle();
        issue_tag = 4'd1; issue_rd = 5'd6;
        tick();
        issue_tag = 4'd2;
        commit_tag = 4'd1; commit_rd = 5'd6; commit_value = 32'h66;
        rs_addr = {5'd6, 5'd0};
        #1;
        vectors++;
        if (p1 !== {1'b0, 4'd0, 4'd1, 32'h66}) begin
            miscompares++; $display("FAIL same_cycle_bypass got %h want %h", p1, {1'b0, 4'd0, 4'd1, 32'h66});
        end
        tick(); idle();
        #1;
        vectors++;
        if (p1 !== {1'b1, 4'd2, 4'd2, 32'd0}) begin
            miscompares++; $display("FAIL issue_over_commit got %h want %h", p1, {1'b1, 4'd2, 4'd2, 32'd0});
        end
        flush = 1'b1;
        tick(); idle();
        #1;
        vectors++;
        if (p1 !== {1'b0, 4'd0, 4'd0, 32'h66}) begin
            miscompares++; $display("FAIL issue_over_commit_value got %h want %h", p1, {1'b0, 4'd0, 4'd0, 32'h66});
        end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 1; i <= 4; i++) begin
            issue_tag = 4'(i); issue_rd = 5'(i);
            tick();
        end
        idle();
        rs_addr = {5'd4, 5'd1};
        #1;
        vectors++;
        if ({p0, p1} !== {1'b1, 4'd1, 4'd1, 32'd0, 1'b1, 4'd4, 4'd4, 32'd0}) begin
            miscompares++; $display("FAIL pre_flush_busy got %h want %h", {p0, p1},
                                    {1'b1, 4'd1, 4'd1, 32'd0, 1'b1, 4'd4, 4'd4, 32'd0});
        end
        flush = 1'b1; issue_tag = 4'd5; issue_rd = 5'd1;
        commit_tag = 4'd2; commit_rd = 5'd2; commit_value = 32'h22;
        tick(); idle();
        #1;
        vectors++;
        if ({p0, p1} !== 82'd0) begin
            miscompares++; $display("FAIL flush_x1_x4 got %h want 0", {p0, p1});
        end
        rs_addr = {5'd3, 5'd2};
        #1;
        vectors++;
        if ({p0, p1} !== {1'b0, 4'd0, 4'd0, 32'h22, 41'd0}) begin
            miscompares++; $display("FAIL flush_x2_x3 got %h want %h", {p0, p1}, {1'b0, 4'd0, 4'd0, 32'h22, 41'd0});
        end
    endtask

    task automatic test_hold();
        idle();
        rdy = 1'b0;
        issue_tag = 4'd4; issue_rd = 5'd7;
        commit_tag = 4'd1; commit_rd = 5'd3; commit_value = 32'h99;
        rs_addr = 10'd0;
        #1;
        vectors++;
        if ({p0, p1} !== 82'd0) begin
            miscompares++; $display("FAIL hold_x0_read got %h want 0", {p0, p1});
        end
        tick(); idle();
        rs_addr = {5'd3, 5'd7};
        #1;
        vectors++;
        if ({p0, p1} !== 82'd0) begin
            miscompares++; $display("FAIL hold_no_change got %h want 0", {p0, p1});
        end
    endtask

    task automatic test_back_to_back();
        idle();
        issue_tag = 4'd5; issue_rd = 5'd0;
        tick();
        issue_tag = 4'd6; issue_rd = 5'd8;
        tick();
        issue_tag = 4'd7; issue_rd = 5'd9;
        tick(); idle();
        rs_addr = {5'd8, 5'd0};
        #1;
        vectors++;
        if ({p0, p1} !== {41'd0, 1'b1, 4'd6, 4'd6, 32'd0}) begin
            miscompares++; $display("FAIL x0_never_busy got %h want %h", {p0, p1}, {41'd0, 1'b1, 4'd6, 4'd6, 32'd0});
        end
        rob_q_ready = 2'b10; rob_q_value = {32'h88, 32'd0};
        #1;
        vectors++;
        if (p1 !== {1'b0, 4'd0, 4'd6, 32'h88}) begin
            miscompares++; $display("FAIL port1_rob_bypass got %h want %h", p1, {1'b0, 4'd0, 4'd6, 32'h88});
        end
        rs_addr = {5'd9, 5'd9}; rob_q_ready = 2'b01; rob_q_value = {32'd0, 32'h99};
        #1;
        vectors++;
        if ({p0, p1} !== {1'b0, 4'd0, 4'd7, 32'h99, 1'b1, 4'd7, 4'd7, 32'd0}) begin
            miscompares++; $display("FAIL shared_reg_ports got %h want %h", {p0, p1},
                                    {1'b0, 4'd0, 4'd7, 32'h99, 1'b1, 4'd7, 4'd7, 32'd0});
        end
    endtask

    initial begin
        rst = 1'b1; rs_addr = 10'd0;
        idle();
        test_reset();
        test_issue();
        test_commit();
        test_rename_chain();
        test_same_cycle();
        test_flush();
        test_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width; NREG = 2^REG_AW.
REQ-003 SHALL have parameter ROB_W, default 4, RoB tag width; tag 0 = "no entry".
REQ-004 SHALL have parameter NRD, default 2, number of read ports.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rdy  input  1  global enable; low = hold all state.
REQ-008 SHALL have port flush  input  1  mispredict; clear all rename state.
REQ-009 SHALL have port issue_tag  input  ROB_W  tag of issuing instruction; 0 = no issue.
REQ-010 SHALL have port issue_rd  input  REG_AW  destination of issuing instruction.
REQ-011 SHALL have port commit_tag  input  ROB_W  tag of committing instruction; 0 = no commit.
REQ-012 SHALL have port commit_rd  input  REG_AW  destination of committing instruction.
REQ-013 SHALL have port commit_value  input  XLEN  committed result.
REQ-014 SHALL have port rs_addr  input  NRD*REG_AW  read addresses; port k in slice k.
REQ-015 SHALL have port rob_q_tag  output  NRD*ROB_W  per-port tag sent to RoB for result lookup.
REQ-016 SHALL have port rob_q_ready  input  NRD  per-port: queried RoB entry has result.
REQ-017 SHALL have port rob_q_value  input  NRD*XLEN  per-port RoB result.
REQ-018 SHALL have port rs_value  output  NRD*XLEN  per-port operand value.
REQ-019 SHALL have port rs_dep  output  NRD  per-port: operand still pending.
REQ-020 SHALL have port rs_tag  output  NRD*ROB_W  per-port pending tag; 0 when rs_dep=0.

Function
REQ-021 SHALL hold per register: value[XLEN], busy bit, tag[ROB_W]; register 0 never written, never busy.
REQ-022 SHALL resolve each read port combinationally (0-cycle) against pre-clock-edge state; current-cycle issue never affects current-cycle reads.
REQ-023 SHALL drive rob_q_tag_k = tag[rs_k] when busy[rs_k], else 0.
REQ-024 SHALL resolve in priority: rs_k=0 -> value 0, dep 0; not busy -> value[rs_k]; busy and commit_tag=tag[rs_k]!=0 -> commit_value; busy and rob_q_ready_k -> rob_q_value_k; else dep 1, tag tag[rs_k], value 0.
REQ-025 SHALL, on commit (commit_tag!=0, commit_rd!=0, rdy), write value[commit_rd] <= commit_value at clock edge.
REQ-026 SHALL clear busy/tag of commit_rd only when busy and tag equals commit_tag; a newer rename is preserved.
REQ-027 SHALL, on issue (issue_tag!=0, issue_rd!=0, rdy, !flush), set busy[issue_rd]<=1, tag[issue_rd]<=issue_tag.
REQ-028 SHALL give issue precedence over commit clear when issue_rd=commit_rd in the same cycle; value still written.
REQ-029 SHALL, on flush with rdy, clear every busy and tag; a same-cycle commit value write still happens; same-cycle issue ignored.
REQ-030 SHALL, with rdy=0, hold all state; combinational read outputs remain valid.
REQ-031 SHALL support NRD independent ports; any ports may address the same register.

Reset
REQ-032 SHALL, on rst at clock edge (regardless of rdy), zero all values, busy bits and tags.
REQ-033 SHALL have outputs after reset: rs_value=0, rs_dep=0, rs_tag=0, rob_q_tag=0 for all ports.
REQ-034 SHALL give rst priority over flush, issue and commit.

Verification
REQ-035 SHALL pass: issue tag 3 rd 5; next cycle read x5 with rob_q_ready=0 -> rs_dep=1, rs_tag=3, rob_q_tag=3.
REQ-036 SHALL pass: x5 busy tag 3, commit tag 3 value 0xDEAD, same-cycle read x5 -> rs_value=0xDEAD, rs_dep=0; next cycle busy cleared, value[5]=0xDEAD.
REQ-037 SHALL pass: x5 renamed tag 3 then tag 7; commit tag 3 -> value written, x5 still dep tag 7.
REQ-038 SHALL pass: same cycle issue tag 2 rd 6 and commit tag 1 rd 6 (busy tag 1) -> x6 busy tag 2, value[6]=commit_value.
REQ-039 SHALL pass: x1..x4 busy, flush with issue tag 5 rd 1 -> next cycle all rs_dep=0, x1 not busy.
REQ-040 SHALL pass: rdy=0 with issue/commit asserted -> no state change; read x0 on both ports -> value 0, dep 0.
